// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for the shared execute-stage ALU, with a one-entry response slot.
// Optional saturating grant counters are built when ALU_SHARE_STAT_EN is defined.
module alu_share_arbiter #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ID_W   = 1,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [XLEN-1:0]   req0_data1,
  input  logic [XLEN-1:0]   req0_data2,
  input  logic [6:0]        req0_optype,
  input  logic [2:0]        req0_aluop,
  input  logic [6:0]        req0_funct7,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [XLEN-1:0]   req1_data1,
  input  logic [XLEN-1:0]   req1_data2,
  input  logic [6:0]        req1_optype,
  input  logic [2:0]        req1_aluop,
  input  logic [6:0]        req1_funct7,
  output logic [XLEN-1:0]   alu_data1,
  output logic [XLEN-1:0]   alu_data2,
  output logic [6:0]        alu_optype,
  output logic [2:0]        alu_aluop,
  output logic [6:0]        alu_funct7,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [XLEN-1:0]   rsp_result,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic [STAT_W-1:0] stat_grant0,
  output logic [STAT_W-1:0] stat_grant1
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t state_q, state_d;
  logic   last_grant_q;
  logic   slot_free, grant0, grant1;

  // Arbitration, ALU operand mux and slot next-state
  always_comb begin
    state_d    = state_q;
    slot_free  = 1'b0;
    grant0     = 1'b0;
    grant1     = 1'b0;
    alu_data1  = '0;
    alu_data2  = '0;
    alu_optype = '0;
    alu_aluop  = '0;
    alu_funct7 = '0;

    slot_free = !rst && ((state_q == S_EMPTY) || rsp_ready);
    if (slot_free) begin
      if (req0_valid && (!req1_valid || last_grant_q)) grant0 = 1'b1;
      else if (req1_valid)                             grant1 = 1'b1;
    end

    if (grant0) begin
      alu_data1  = req0_data1;
      alu_data2  = req0_data2;
      alu_optype = req0_optype;
      alu_aluop  = req0_aluop;
      alu_funct7 = req0_funct7;
    end else if (grant1) begin
      alu_data1  = req1_data1;
      alu_data2  = req1_data2;
      alu_optype = req1_optype;
      alu_aluop  = req1_aluop;
      alu_funct7 = req1_funct7;
    end

    if (grant0 || grant1)                      state_d = S_FULL;
    else if (state_q == S_FULL && rsp_ready)   state_d = S_EMPTY;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state_q == S_FULL);

  // Response slot: a grant captures the ALU outputs; otherwise contents hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      last_grant_q <= 1'b1;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant0 || grant1) begin
        rsp_result   <= alu_result;
        rsp_zero     <= alu_zero;
        rsp_carry    <= alu_carry;
        rsp_id       <= grant1 ? ID_W'(1) : '0;
        last_grant_q <= grant1;
      end
    end
  end

`ifdef ALU_SHARE_STAT_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  logic [STAT_W-1:0] cnt0_q, cnt1_q;

  // Saturating per-requester grant counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (grant0 && cnt0_q != STAT_MAX) cnt0_q <= cnt0_q + STAT_W'(1);
      if (grant1 && cnt1_q != STAT_MAX) cnt1_q <= cnt1_q + STAT_W'(1);
    end
  end

  assign stat_grant0 = cnt0_q;
  assign stat_grant1 = cnt1_q;
`else
  assign stat_grant0 = '0;
  assign stat_grant1 = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU plus a transaction-level model of the arbiter and response slot.
module tb_alu_share_arbiter;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ID_W   = 1;
  localparam int unsigned STAT_W = 16;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_SUB   = 7'b0100000;
  localparam logic [2:0] ADD_SUB = 3'd0, SLL = 3'd1, SLT = 3'd2, XOR_OP = 3'd4,
                         SRL_SRA = 3'd5, OR_OP = 3'd6, AND_OP = 3'd7;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [XLEN-1:0] req0_data1, req0_data2, req1_data1, req1_data2;
  logic [6:0] req0_optype, req0_funct7, req1_optype, req1_funct7;
  logic [2:0] req0_aluop, req1_aluop;
  logic [XLEN-1:0] alu_data1, alu_data2, alu_result;
  logic [6:0] alu_optype, alu_funct7;
  logic [2:0] alu_aluop;
  logic alu_zero, alu_carry;
  logic rsp_valid, rsp_ready, rsp_zero, rsp_carry;
  logic [ID_W-1:0] rsp_id;
  logic [XLEN-1:0] rsp_result;
  logic [STAT_W-1:0] stat_grant0, stat_grant1;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic m_valid, m_zero, m_carry, m_last;
  int   m_id;
  logic [XLEN-1:0] m_res;
  int   m_cnt0, m_cnt1;
  logic hold0, hold1;

  always #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(XLEN), .ID_W(ID_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_data1(req0_data1), .req0_data2(req0_data2),
    .req0_optype(req0_optype), .req0_aluop(req0_aluop), .req0_funct7(req0_funct7),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_data1(req1_data1), .req1_data2(req1_data2),
    .req1_optype(req1_optype), .req1_aluop(req1_aluop), .req1_funct7(req1_funct7),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_optype(alu_optype),
    .alu_aluop(alu_aluop), .alu_funct7(alu_funct7),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .stat_grant0(stat_grant0), .stat_grant1(stat_grant1)
  );

  // Reference ALU: {carry, result}
  function automatic logic [XLEN:0] alu_ref(input logic [6:0] op, input logic [2:0] fn,
                                            input logic [6:0] f7, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [XLEN:0] r;
    case (fn)
      ADD_SUB: r = (op == OP_RTYPE && f7 == F7_SUB) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      SLL:     r = {1'b0, a << b[4:0]};
      SLT:     r = (XLEN+1)'($signed(a) < $signed(b));
      XOR_OP:  r = {1'b0, a ^ b};
      SRL_SRA: r = (f7 == F7_SUB) ? {1'b0, XLEN'($signed(a) >>> b[4:0])} : {1'b0, a >> b[4:0]};
      OR_OP:   r = {1'b0, a | b};
      AND_OP:  r = {1'b0, a & b};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [XLEN:0] alu_out;
  always_comb alu_out = alu_ref(alu_optype, alu_aluop, alu_funct7, alu_data1, alu_data2);
  assign alu_result = alu_out[XLEN-1:0];
  assign alu_carry  = alu_out[XLEN];
  assign alu_zero   = (alu_out[XLEN-1:0] == '0);

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_id = 0; m_res = '0; m_zero = 1'b0; m_carry = 1'b0;
    m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0; hold0 = 1'b0; hold1 = 1'b0;
  endtask

  // One clock: check combinational outputs, advance model on the edge, check the slot
  task automatic step();
    int g;
    logic r, free;
    logic [XLEN-1:0] e_d1, e_d2;
    logic [16:0] e_ctrl;
    logic [XLEN:0] res;
    #1;
    r    = rst;
    free = !r && (!m_valid || rsp_ready);
    g = -1;
    if (free) begin
      if (req0_valid && req1_valid) g = m_last ? 0 : 1;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
    end
    e_d1 = '0; e_d2 = '0; e_ctrl = '0;
    if (g == 0) begin e_d1 = req0_data1; e_d2 = req0_data2; e_ctrl = {req0_optype, req0_aluop, req0_funct7}; end
    if (g == 1) begin e_d1 = req1_data1; e_d2 = req1_data2; e_ctrl = {req1_optype, req1_aluop, req1_funct7}; end
    check_eq("req0_ready", 64'(req0_ready), 64'(g == 0));
    check_eq("req1_ready", 64'(req1_ready), 64'(g == 1));
    check_eq("alu_data1", 64'(alu_data1), 64'(e_d1));
    check_eq("alu_data2", 64'(alu_data2), 64'(e_d2));
    check_eq("alu_ctrl", 64'({alu_optype, alu_aluop, alu_funct7}), 64'(e_ctrl));
    res = alu_ref(e_ctrl[16:10], e_ctrl[9:7], e_ctrl[6:0], e_d1, e_d2);
    hold0 = !r && req0_valid && (g != 0);
    hold1 = !r && req1_valid && (g != 1);
    @(posedge clk);
    if (r) model_reset();
    else if (g >= 0) begin
      m_valid = 1'b1; m_id = g; m_last = (g == 1);
      m_res = res[XLEN-1:0]; m_carry = res[XLEN]; m_zero = (res[XLEN-1:0] == '0);
      if (g == 0 && m_cnt0 < (2**STAT_W) - 1) m_cnt0++;
      if (g == 1 && m_cnt1 < (2**STAT_W) - 1) m_cnt1++;
    end else if (m_valid && rsp_ready) m_valid = 1'b0;
    #1;
    check_eq("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    if (m_valid || r) begin
      check_eq("rsp_id", 64'(rsp_id), 64'(m_id));
      check_eq("rsp_result", 64'(rsp_result), 64'(m_res));
      check_eq("rsp_zero", 64'(rsp_zero), 64'(m_zero));
      check_eq("rsp_carry", 64'(rsp_carry), 64'(m_carry));
    end
`ifdef ALU_SHARE_STAT_EN
    check_eq("stat_grant0", 64'(stat_grant0), 64'(m_cnt0));
    check_eq("stat_grant1", 64'(stat_grant1), 64'(m_cnt1));
`else
    check_eq("stat_grant0", 64'(stat_grant0), 64'd0);
    check_eq("stat_grant1", 64'(stat_grant1), 64'd0);
`endif
  endtask

  task automatic set_req0(input logic v, input logic [6:0] op, input logic [2:0] fn,
                          input logic [6:0] f7, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req0_valid = v; req0_optype = op; req0_aluop = fn; req0_funct7 = f7; req0_data1 = a; req0_data2 = b;
  endtask

  task automatic set_req1(input logic v, input logic [6:0] op, input logic [2:0] fn,
                          input logic [6:0] f7, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req1_valid = v; req1_optype = op; req1_aluop = fn; req1_funct7 = f7; req1_data1 = a; req1_data2 = b;
  endtask

  // Random request; a stalled requester keeps its fields or drops valid
  task automatic rand_reqs();
    if (hold0) begin
      if ($urandom_range(7) == 0) req0_valid = 1'b0;
    end else
      set_req0($urandom_range(3) != 0, $urandom_range(1) ? OP_RTYPE : OP_ITYPE, 3'($urandom_range(7)),
               $urandom_range(1) ? F7_SUB : 7'h00, $urandom, $urandom);
    if (hold1) begin
      if ($urandom_range(7) == 0) req1_valid = 1'b0;
    end else
      set_req1($urandom_range(3) != 0, $urandom_range(1) ? OP_RTYPE : OP_ITYPE, 3'($urandom_range(7)),
               $urandom_range(1) ? F7_SUB : 7'h00, $urandom, $urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1; rsp_ready = 1'b0;
    set_req0(1'b0, '0, '0, '0, '0, '0);
    set_req1(1'b0, '0, '0, '0, '0, '0);
    @(posedge clk);
    do_reset();

    // Single requester ADD
    rsp_ready = 1'b1;
    set_req0(1'b1, OP_ITYPE, ADD_SUB, 7'h00, 32'd5, 32'd7);
    step();
    check_eq("add_id", 64'(rsp_id), 64'd0);
    check_eq("add_result", 64'(rsp_result), 64'd12);
    check_eq("add_zero", 64'(rsp_zero), 64'd0);
    req0_valid = 1'b0;
    step();

    // Tie after reset alternates 0,1,0,1 with no bubbles
    do_reset();
    set_req0(1'b1, OP_ITYPE, OR_OP, 7'h00, 32'h1, 32'h2);
    set_req1(1'b1, OP_RTYPE, AND_OP, 7'h00, 32'hFF, 32'h0F);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("tie_id", 64'(rsp_id), 64'(i % 2));
      check_eq("tie_valid", 64'(rsp_valid), 64'd1);
    end
    set_req0(1'b0, '0, '0, '0, '0, '0);
    set_req1(1'b0, '0, '0, '0, '0, '0);
    step();

    // Backpressure holds the XOR result; release grants req1 in the same cycle
    set_req0(1'b1, OP_ITYPE, XOR_OP, 7'h00, 32'hF0F0F0F0, 32'h0F0F0F0F);
    step();
    req0_valid = 1'b0;
    set_req1(1'b1, OP_ITYPE, ADD_SUB, 7'h00, 32'd1, 32'd2);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_hold", 64'(rsp_result), 64'hFFFFFFFF);
    end
    rsp_ready = 1'b1;
    step();
    check_eq("bp_release_id", 64'(rsp_id), 64'd1);
    check_eq("bp_release_res", 64'(rsp_result), 64'd3);

    // Subtract to zero from requester 1
    set_req1(1'b1, OP_RTYPE, ADD_SUB, F7_SUB, 32'd9, 32'd9);
    step();
    check_eq("sub_result", 64'(rsp_result), 64'd0);
    check_eq("sub_zero", 64'(rsp_zero), 64'd1);
    check_eq("sub_id", 64'(rsp_id), 64'd1);

    // Reset while FULL and stalled, then first tie goes to requester 0
    set_req1(1'b1, OP_ITYPE, ADD_SUB, 7'h00, 32'd4, 32'd4);
    step();
    rsp_ready = 1'b0;
    step();
    do_reset();
    check_eq("rst_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_result", 64'(rsp_result), 64'd0);
    rsp_ready = 1'b1;
    set_req0(1'b1, OP_ITYPE, SLL, 7'h00, 32'd1, 32'd4);
    set_req1(1'b1, OP_ITYPE, SLL, 7'h00, 32'd1, 32'd8);
    step();
    check_eq("rst_tie_id", 64'(rsp_id), 64'd0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 2000; i++) begin
      rand_reqs();
      rsp_ready = ($urandom_range(3) != 0);
      rst = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0;

`ifdef ALU_SHARE_STAT_EN
    // Saturation of requester 0 counter
    do_reset();
    set_req1(1'b0, '0, '0, '0, '0, '0);
    set_req0(1'b1, OP_ITYPE, ADD_SUB, 7'h00, 32'd1, 32'd1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    check_eq("sat_grant0", 64'(stat_grant0), 64'd65535);
    check_eq("sat_grant1", 64'(stat_grant1), 64'd0);
`else
    check_eq("nostat_grant0", 64'(stat_grant0), 64'd0);
    check_eq("nostat_grant1", 64'(stat_grant1), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters.
- Requester 0 is the execute-stage pipeline; requester 1 is the address/branch-compare helper unit.
- Round-robin grants, a muxed operand bus to the ALU, and a one-entry registered response slot carrying the requester ID, with valid/ready handshakes on both sides.
- Sits in the execute stage; the ALU instance is outside this block, so this block is its sequencer and front end.

Parameters:
- XLEN, 32, datapath width of operands and result.
- ID_W, 1, width of the requester ID returned with each response.
- STAT_W, 16, width of the optional grant counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester N presents an operation.
- req0_ready / req1_ready  out  1  requester N's operation is accepted this cycle.
- reqN_data1, reqN_data2  in  XLEN  operands.
- reqN_optype  in  7  opcode class (OP_ITYPE / OP_RTYPE).
- reqN_aluop  in  3  ALU operation code (ADD_SUB, SLT, AND, OR, XOR, SLL, SRL_SRA).
- reqN_funct7  in  7  funct7 qualifier.
- alu_data1, alu_data2  out  XLEN  operands driven to the ALU.
- alu_optype  out  7, alu_aluop  out  3, alu_funct7  out  7  ALU control.
- alu_result  in  XLEN, alu_zero  in  1, alu_carry  in  1  ALU outputs (combinational, same cycle).
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  requester that issued the operation.
- rsp_result  out  XLEN, rsp_zero  out  1, rsp_carry  out  1  captured ALU outputs.
- stat_grant0 / stat_grant1  out  STAT_W  grant counters (see Optional Feature).

Behaviour:
- State machine on the response slot:
  - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - slot_free = EMPTY | (FULL & rsp_ready).
- Arbitration is combinational, and only while slot_free:
  - If exactly one req valid, that requester is granted.
  - If both are valid, grant the requester other than last_grant.
  - At most one reqN_ready is high per cycle; reqN_ready = grantN & slot_free.
  - reqN_ready does not depend on its own reqN_valid beyond arbitration. A requester that is not valid is never granted.
- ALU drive:
  - On a grant, the alu_* outputs mirror the granted requester's fields in the same cycle.
  - With no grant, all alu_* outputs are driven to 0.
- Transfer on reqN_valid & reqN_ready. At that clock edge:
  - rsp_result, rsp_zero and rsp_carry capture the ALU outputs.
  - rsp_id is set to N.
  - rsp_valid becomes 1.
  - last_grant is set to N.
- Latency is one cycle: issue in cycle T gives rsp_valid in T+1.
- FULL with rsp_ready=0:
  - Both readys are 0.
  - The rsp_* outputs hold stable until accepted; this is the stall.
- FULL with rsp_ready=1 and a new grant: pop and push on the same edge. The slot stays FULL with the new data, giving one op per cycle sustained.
- FULL with rsp_ready=1 and no request: go to EMPTY.
- Requesters must hold their fields stable while valid and not ready. Dropping valid without acceptance is allowed; no state changes.
- Result width: carry is ALU bit 32 and is passed through unmodified. No arithmetic in this block.
- Reset:
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_carry=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Stat counters are 0.
- Reset mid-operation: any in-flight response is discarded and no handshake completes in the reset cycle. Readys are 0 while rst=1.

Optional Feature:
- Macro: ALU_SHARE_STAT_EN.
- Defined: stat_grantN increments by 1 on each accepted transfer for requester N, saturating at 2^STAT_W-1 (no wrap). Cleared by rst.
- Undefined: the counters are not built and stat_grant0/1 are tied to 0. Ports stay present so the interface is identical.

Test Plan:
- Single requester: req0 ADD_SUB ITYPE, data1=5, data2=7 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
- Tie after reset: both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; one response per cycle, no bubbles.
- Backpressure: rsp_ready=0 for 3 cycles with slot FULL -> both readys 0; rsp_* stable (e.g. XOR 0xF0F0F0F0^0x0F0F0F0F gives 0xFFFFFFFF held); on rsp_ready=1 the next grant happens in the same cycle.
- Zero/carry path: req1 SUB RTYPE with funct7=FUNCT_R_SUBSRA, data1=9, data2=9 -> rsp_result=0, rsp_zero=1, rsp_id=1.
- Reset mid-stream: assert rst while FULL with rsp_ready=0 -> next cycle rsp_valid=0, all rsp_* 0; first tie afterwards grants requester 0.
- With ALU_SHARE_STAT_EN: 70000 grants to req0 (STAT_W=16) -> stat_grant0=65535 saturated, stat_grant1 unchanged. Without the macro -> both counters read 0.
